// File: rtl/rcpu_pkg.sv
// Shared definitions for the RCPU command driver: opcodes, the illegal-op
// sentinel result and the driver FSM state encoding.
package rcpu_pkg;

    localparam logic [2:0]  OP_ADD = 3'b000;
    localparam logic [2:0]  OP_SUB = 3'b001;
    localparam logic [2:0]  OP_AND = 3'b100;
    localparam logic [2:0]  OP_OR  = 3'b110;

    // -200 as a 16-bit two's-complement value; what the core returns for unknown ops
    localparam logic [15:0] ILLEGAL_RESULT = 16'hFF38;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } drv_state_t;

endpackage

// File: rtl/rcpu_driver_if.sv
// Command, core-facing and response signals of the RCPU driver.
// The slave modport is the driver itself; master is the host plus core side.
interface rcpu_driver_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [15:0]      cpu_instruction;
    logic [WIDTH-1:0] cpu_operand1;
    logic [WIDTH-1:0] cpu_operand2;
    logic [WIDTH-1:0] cpu_result;
    logic             cpu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_illegal;
    logic             rsp_mismatch;

    logic [15:0]      txn_count;
    logic [15:0]      err_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cpu_result, cpu_zero, rsp_ready,
        output cmd_ready, cpu_instruction, cpu_operand1, cpu_operand2,
               rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_mismatch,
               txn_count, err_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cpu_result, cpu_zero, rsp_ready,
        input  cmd_ready, cpu_instruction, cpu_operand1, cpu_operand2,
               rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_mismatch,
               txn_count, err_count
    );
endinterface

// File: rtl/rcpu_ref_alu.sv
// Combinational reference model of the RCPU ALU: expected result, zero flag
// and illegal-opcode indication for a given op and operand pair.
module rcpu_ref_alu
    import rcpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    always_comb begin
        result  = WIDTH'(ILLEGAL_RESULT);
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rcpu_driver.sv
// Command-side driver for the RCPU core: issues one ALU command, waits out the
// core latency, captures and checks the result, then returns it as a response.
module rcpu_driver
    import rcpu_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int WIDTH   = 16
) (
    input  logic         clk,
    input  logic         reset,
    rcpu_driver_if.slave bus
);

    localparam int CNT_W = $clog2(LATENCY) + 1;

    drv_state_t       state_reg;
    logic [CNT_W-1:0] hold_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cmd_ready_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_zero_reg;
    logic             rsp_illegal_reg;
    logic             rsp_mismatch_reg;
    logic [15:0]      txn_count_reg;
    logic [15:0]      err_count_reg;

    logic [WIDTH-1:0] ref_result;
    logic             ref_zero;
    logic             ref_illegal;

    // The model looks at the issued command, which is stable throughout CAPTURE
    rcpu_ref_alu #(
        .WIDTH(WIDTH)
    ) u_ref_alu (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .result (ref_result),
        .zero   (ref_zero),
        .illegal(ref_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            hold_reg         <= '0;
            op_reg           <= OP_ADD;
            a_reg            <= '0;
            b_reg            <= '0;
            cmd_ready_reg    <= 1'b1;
            rsp_valid_reg    <= 1'b0;
            rsp_result_reg   <= '0;
            rsp_zero_reg     <= 1'b0;
            rsp_illegal_reg  <= 1'b0;
            rsp_mismatch_reg <= 1'b0;
            txn_count_reg    <= '0;
            err_count_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_reg) begin
                        op_reg        <= bus.cmd_op;
                        a_reg         <= bus.cmd_a;
                        b_reg         <= bus.cmd_b;
                        hold_reg      <= '0;
                        cmd_ready_reg <= 1'b0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    hold_reg <= hold_reg + CNT_W'(1);
                    if (hold_reg == CNT_W'(LATENCY - 1)) begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_result_reg   <= bus.cpu_result;
                    rsp_zero_reg     <= bus.cpu_zero;
                    rsp_illegal_reg  <= ref_illegal;
                    rsp_mismatch_reg <= (bus.cpu_result != ref_result) ||
                                        (bus.cpu_zero != ref_zero);
                    rsp_valid_reg    <= 1'b1;
                    state_reg        <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        if (txn_count_reg != 16'hFFFF) begin
                            txn_count_reg <= txn_count_reg + 16'd1;
                        end
                        if (rsp_mismatch_reg && (err_count_reg != 16'hFFFF)) begin
                            err_count_reg <= err_count_reg + 16'd1;
                        end
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready       = cmd_ready_reg;
    assign bus.cpu_instruction = {13'd0, op_reg};
    assign bus.cpu_operand1    = a_reg;
    assign bus.cpu_operand2    = b_reg;
    assign bus.rsp_valid       = rsp_valid_reg;
    assign bus.rsp_result      = rsp_result_reg;
    assign bus.rsp_zero        = rsp_zero_reg;
    assign bus.rsp_illegal     = rsp_illegal_reg;
    assign bus.rsp_mismatch    = rsp_mismatch_reg;
    assign bus.txn_count       = txn_count_reg;
    assign bus.err_count       = err_count_reg;

endmodule

// File: doc/rcpu_driver.md
# rcpu_driver

Command-side driver for the 16-bit RCPU execution core. Accepts ALU commands over a valid/ready interface, drives the core's instruction and operand inputs, and waits out the core's fixed pipeline latency. It then captures result and zero flag and returns them over a response valid/ready interface. A built-in reference model checks each result and keeps saturating transaction and mismatch counters.

## Interface
- `LATENCY`, 3: cycles the driven instruction/operands are held before capture; must be ≥3.
- `WIDTH`, 16: data width; must match the core.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: driver can accept a command.
- `cmd_op` in 3: opcode: 000 ADD, 001 SUB, 100 AND, 110 OR, others illegal.
- `cmd_a` in WIDTH: operand 1.
- `cmd_b` in WIDTH: operand 2.
- `cpu_instruction` out 16: to core `instruction`; bits [2:0] = op, [15:3] = 0.
- `cpu_operand1` out WIDTH: to core operand1.
- `cpu_operand2` out WIDTH: to core operand2.
- `cpu_result` in WIDTH: from core result.
- `cpu_zero` in 1: from core zero_flag.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out WIDTH: captured core result.
- `rsp_zero` out 1: captured core zero flag.
- `rsp_illegal` out 1: command opcode was illegal.
- `rsp_mismatch` out 1: captured result/zero differs from the reference model.
- `txn_count` out 16: completed responses; saturates at 0xFFFF.
- `err_count` out 16: responses with `rsp_mismatch`=1; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`, register op/a/b, clear the hold counter, go to ISSUE.
- ISSUE:
  - The `cpu_*` outputs present the registered command.
  - The hold counter increments every cycle.
  - After LATENCY cycles in ISSUE, go to CAPTURE.
- CAPTURE (one cycle):
  - Sample `cpu_result` and `cpu_zero` into `rsp_result`/`rsp_zero`.
  - Compute the expected result with the reference model: ADD/SUB modulo 2^WIDTH, AND, OR; illegal op gives 0xFF38 (−200).
  - Expected zero = (expected result == 0).
  - Set `rsp_mismatch` if either result or zero differs.
  - Set `rsp_illegal` for any op outside {000,001,100,110}.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; all `rsp_*` fields stay stable until the handshake.
  - On `rsp_valid`&`rsp_ready`: increment `txn_count`, increment `err_count` if mismatch, go to IDLE.
- `cpu_*` outputs hold the last issued command outside ISSUE. The core free-runs, so only the sample taken in CAPTURE is meaningful.
- An illegal opcode is still issued. It is not a driver error: mismatch depends only on the comparison.

## Timing
- Reset (async assert, release synchronized to `clk`):
  - state IDLE, `cmd_ready`=1, `rsp_valid`=0.
  - All `rsp_*` fields 0.
  - `cpu_instruction`=0 (ADD), `cpu_operand1`=0, `cpu_operand2`=0.
  - Both counters 0.
- Command accepted at edge N:
  - `cpu_*` valid from N.
  - Capture at edge N+LATENCY+1.
  - `rsp_valid` high from N+LATENCY+1.
- Minimum command-to-command spacing is LATENCY+3 cycles with `rsp_ready` held high. There is no overlap: `cmd_ready`=0 in ISSUE, CAPTURE and RESP.
- `rsp_ready` low: stall in RESP indefinitely; no counter update.
- `rsp_ready` high before `rsp_valid`: no effect.
- `cmd_valid` deasserted without acceptance: no state change.
- Reset asserted mid-transaction: the transaction is dropped immediately, with no response and no counter update.
- Counter saturation: at 0xFFFF, further increments are ignored. `txn_count` and `err_count` are independent.

## Structure
- Shared package `rcpu_pkg`:
  - Opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR.
  - ILLEGAL_RESULT = 16'hFF38.
  - The driver FSM state enum.
- Sub-module `rcpu_ref_alu`: combinational expected result/zero/illegal from op, a and b. It is reused by future core testbenches.

## Test plan
- ADD a=5 b=3 → `rsp_result`=0x0008, `rsp_zero`=0, illegal=0, mismatch=0; `rsp_valid` exactly LATENCY+1 edges after accept.
- SUB a=0x0007 b=0x0007 → result 0x0000, zero=1. ADD 0xFFFF+0x0001 → 0x0000, zero=1 (wrap-around).
- Op 3'b010 a=1 b=1 → result 0xFF38, `rsp_illegal`=1, mismatch=0.
- Backpressure:
  - Stimulus: `rsp_ready` low for 6 cycles in RESP while `cmd_valid` is held high.
  - Required: response stable, `cmd_ready`=0, counters unchanged; one txn counted after the handshake.
- Reset pulse during ISSUE of AND 0xF0F0&0x0FF0:
  - All outputs return to reset values asynchronously.
  - No `rsp_valid`; `txn_count`=0.
  - The next OR 0x00F0|0x0F00 returns 0x0FF0.
- Core forced to return wrong result 0x1234 for ADD 1+1 → mismatch=1, `err_count`=1, `txn_count`=1.
